sdio_apb_bridge: RTL and testbench



---
 rtl/sdio_apb_bridge.sv | 136 +++++++++++++
 tb/tb_sdio_apb_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_apb_bridge.sv
// rtl/sdio_apb_bridge.sv - APB3 slave driving the SD host 8-bit register bus
// Stretches SD-domain write strobes and waits a settle time before read capture.
module sdio_apb_bridge #(
  parameter int SD_WR_CYCLES   = 8,
  parameter int RD_WAIT_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       rstn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       reg_wr_sys,
  output logic       reg_wr_sd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata
);

  localparam logic [7:0] SD_LOAD = 8'(SD_WR_CYCLES - 1);
  localparam logic [7:0] RD_LOAD = 8'(RD_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SYS, SYS_HOLD, WR_SD, RD_WAIT, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] prdata_q, prdata_d;
  logic       both_q, both_d;
  logic       bad_q, bad_d;

  logic cls_sd_range, cls_both, cls_sys, cls_bad;
  logic unused_penable;

  // The latched transaction always completes, so the access phase is not needed.
  assign unused_penable = penable;

  assign cls_sd_range = (paddr <= 8'd40);
  assign cls_both     = (paddr == 8'd8) || (paddr == 8'd31);
  assign cls_sys      = (paddr >= 8'd128) && (paddr <= 8'd136);
  assign cls_bad      = !(cls_sd_range || cls_sys);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      prdata_q <= 8'd0;
      both_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      both_q   <= both_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    both_d     = both_q;
    bad_d      = bad_q;
    reg_wr_sys = 1'b0;
    reg_wr_sd  = 1'b0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel) begin
          addr_d = paddr;
          both_d = cls_both;
          bad_d  = cls_bad;
          if (pwrite) wdata_d = pwdata;
          if (cls_bad) begin
            state_d = DONE;
            if (!pwrite) prdata_d = 8'd0;
          end else if (!pwrite) begin
            state_d = RD_WAIT;
            cnt_d   = RD_LOAD;
          end else if (cls_sys) begin
            state_d = WR_SYS;
          end else begin
            state_d = WR_SD;
            cnt_d   = SD_LOAD;
          end
        end
      end
      WR_SYS: begin
        reg_wr_sys = 1'b1;
        state_d    = SYS_HOLD;
      end
      SYS_HOLD: state_d = DONE;
      WR_SD: begin
        reg_wr_sd = 1'b1;
        // Dual-domain registers get a single sys pulse; a repeat could retrigger DMA.
        reg_wr_sys = both_q && (cnt_q == SD_LOAD);
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          prdata_d = reg_rdata;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        pready  = 1'b1;
        pslverr = bad_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign prdata    = prdata_q;

endmodule

// File: tb/tb_sdio_apb_bridge.sv
// tb/tb_sdio_apb_bridge.sv - scoreboard bench for sdio_apb_bridge
// Driver pushes expected responses; monitor checks them when pready is seen.
module tb_sdio_apb_bridge;

  logic       sys_clk = 1'b0;
  logic       sd_clk  = 1'b0;
  logic       rstn    = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'd0, pwdata = 8'd0;
  logic [7:0] prdata, reg_addr, reg_wdata, reg_rdata;
  logic       pready, pslverr, reg_wr_sys, reg_wr_sd;

  sdio_apb_bridge #(.SD_WR_CYCLES(8), .RD_WAIT_CYCLES(4)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .reg_wr_sys(reg_wr_sys),
    .reg_wr_sd(reg_wr_sd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 sys_clk = ~sys_clk;
  initial begin #2; forever #15 sd_clk = ~sd_clk; end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-file model: sys side acts on the delayed strobe, SD side on sd_clk.
  logic [7:0] mem [256];
  int         dma_starts  = 0;
  bit         all_sys_rst = 1'b0;
  bit         all_sd_rst  = 1'b0;
  bit         sys_pend    = 1'b0;
  int         age         = 0;
  logic [7:0] last_addr   = 8'd0;

  assign reg_rdata = (age >= 2) ? mem[reg_addr] : 8'hEE;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    mem[8'h86] = 8'h0C;
  end

  initial forever begin
    @(posedge sys_clk); #1;
    if (sys_pend) begin
      if (reg_addr == 8'h80) begin
        if (reg_wdata[0]) dma_starts++;
      end else if (reg_addr == 8'h1F) begin
        all_sys_rst = 1'b1;
      end else begin
        mem[reg_addr] = reg_wdata;
      end
    end
    sys_pend = reg_wr_sys;
    if (reg_addr !== last_addr) age = 0;
    else if (age < 10) age++;
    last_addr = reg_addr;
  end

  initial forever begin
    @(posedge sd_clk);
    if (reg_wr_sd) begin
      if (reg_addr == 8'h1F) all_sd_rst = 1'b1;
      else if (reg_addr != 8'h80) mem[reg_addr] = reg_wdata;
    end
  end

  typedef struct {
    bit         wr;
    bit         bad;
    bit         both;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
    int         nsys;
    int         nsd;
  } exp_t;

  exp_t exp_q[$];
  int   stray = 0;

  // Monitor
  initial begin
    bit   busy = 0, have = 0, prev_sys = 0, consec = 0, sysfirst = 0;
    int   lat = 0, nsys = 0, nsd = 0, hold_err = 0;
    exp_t e;
    forever begin
      @(posedge sys_clk); #1;
      if (!rstn) begin
        busy = 0;
        continue;
      end
      if (!busy && psel) begin
        busy = 1; lat = 0; nsys = 0; nsd = 0; hold_err = 0;
        prev_sys = 0; consec = 0; sysfirst = 0;
        have = (exp_q.size() != 0);
        if (have) e = exp_q[0];
      end
      if (!busy) begin
        if (reg_wr_sys || reg_wr_sd) stray++;
        continue;
      end
      lat++;
      if (reg_wr_sys) begin
        if (prev_sys) consec = 1;
        if (reg_wr_sd && nsd == 0) sysfirst = 1;
        nsys++;
      end
      prev_sys = reg_wr_sys;
      if (reg_wr_sd) nsd++;
      if (have) begin
        if (reg_addr !== e.addr) hold_err++;
        if (e.wr && !e.bad && reg_wdata !== e.wdata) hold_err++;
      end
      if (pready) begin
        busy = 0;
        if (!have) begin
          chk("unexpected_pready", 1, 0);
        end else begin
          void'(exp_q.pop_front());
          chk($sformatf("lat_%02h", e.addr), lat, e.lat);
          chk($sformatf("pslverr_%02h", e.addr), int'(pslverr), int'(e.bad));
          chk($sformatf("n_sys_%02h", e.addr), nsys, e.nsys);
          chk($sformatf("n_sd_%02h", e.addr), nsd, e.nsd);
          chk($sformatf("sys_consec_%02h", e.addr), int'(consec), 0);
          chk($sformatf("hold_%02h", e.addr), hold_err, 0);
          if (!e.wr) chk($sformatf("prdata_%02h", e.addr), int'(prdata), int'(e.rdata));
          if (e.both) chk($sformatf("sys_first_%02h", e.addr), int'(sysfirst), 1);
        end
      end
    end
  end

  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] rdata, input int lat, input int nsys,
                      input int nsd, input bit bad, input bit both);
    exp_t e;
    int   guard = 0;
    e.wr = wr; e.bad = bad; e.both = both; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.lat = lat; e.nsys = nsys; e.nsd = nsd;
    exp_q.push_back(e);
    @(negedge sys_clk);
    psel = 1'b1; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge sys_clk);
    penable = 1'b1;
    while (!pready && guard < 40) begin
      @(negedge sys_clk);
      guard++;
      paddr  = ~addr;
      pwdata = ~wdata;
    end
    if (!pready) chk($sformatf("timeout_%02h", addr), 1, 0);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset_outputs", int'({prdata, pready, pslverr, reg_wr_sys, reg_wr_sd, reg_addr, reg_wdata}), 0);
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;

    //    wr  addr   wdata  rdata  lat nsys nsd bad both
    xfer(1, 8'h1D, 8'h5A, 8'h00, 9, 0, 8, 0, 0);
    xfer(1, 8'h80, 8'h01, 8'h00, 3, 1, 0, 0, 0);
    xfer(1, 8'h1F, 8'h01, 8'h00, 9, 1, 8, 0, 1);
    xfer(0, 8'h86, 8'h00, 8'h0C, 5, 0, 0, 0, 0);
    xfer(0, 8'h80, 8'h00, 8'h00, 5, 0, 0, 0, 0);
    xfer(0, 8'h1D, 8'h00, 8'h5A, 5, 0, 0, 0, 0);
    xfer(1, 8'h50, 8'h77, 8'h00, 1, 0, 0, 1, 0);
    xfer(0, 8'h50, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    xfer(1, 8'h08, 8'h3C, 8'h00, 9, 1, 8, 0, 1);
    xfer(1, 8'h28, 8'hC3, 8'h00, 9, 0, 8, 0, 0);
    xfer(1, 8'h29, 8'h11, 8'h00, 1, 0, 0, 1, 0);
    xfer(1, 8'h88, 8'h22, 8'h00, 3, 1, 0, 0, 0);
    xfer(1, 8'h89, 8'h33, 8'h00, 1, 0, 0, 1, 0);
    xfer(0, 8'h28, 8'h00, 8'hC3, 5, 0, 0, 0, 0);
    xfer(0, 8'h7F, 8'h00, 8'h00, 1, 0, 0, 1, 0);

    // Reset in the third WR_SD cycle
    @(negedge sys_clk);
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hAA;
    @(negedge sys_clk);
    penable = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #2;
    chk("abort_wr_sd_before", int'(reg_wr_sd), 1);
    rstn = 1'b0;
    #1;
    chk("abort_outputs", int'({prdata, pready, pslverr, reg_wr_sys, reg_wr_sd, reg_addr, reg_wdata}), 0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (2) @(negedge sys_clk);

    xfer(1, 8'h20, 8'h33, 8'h00, 9, 0, 8, 0, 0);
    xfer(0, 8'h20, 8'h00, 8'h33, 5, 0, 0, 0, 0);

    repeat (4) @(negedge sys_clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("dma_starts", dma_starts, 1);
    chk("all_sys_rst", int'(all_sys_rst), 1);
    chk("all_sd_rst", int'(all_sd_rst), 1);
    chk("mem_1d", int'(mem[8'h1D]), 8'h5A);
    chk("stray_strobes", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule
